// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC snapshot capture engine: register map, FSM encoding,
// CTRL bit positions and the effective-length helper.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } cap_state_e;

    localparam logic [7:0] RegCtrl    = 8'h00;
    localparam logic [7:0] RegDecim   = 8'h01;
    localparam logic [7:0] RegLen     = 8'h02;
    localparam logic [7:0] RegStatus  = 8'h03;
    localparam logic [7:0] RegTrigLvl = 8'h04;
    localparam logic [7:0] RegTrigCfg = 8'h05;
    localparam logic [7:0] DataBase   = 8'h10;

    localparam int unsigned CtrlArm     = 0;
    localparam int unsigned CtrlSwTrig  = 1;
    localparam int unsigned CtrlAbort   = 2;
    localparam int unsigned CtrlChEn    = 8;
    localparam int unsigned TrigCfgFall = 8;

    // A zero or oversized LEN means "fill the whole buffer".
    function automatic logic [16:0] eff_len(input logic [15:0] len, input int unsigned depth);
        if (len == 16'd0 || 32'(len) > depth) begin
            return 17'(depth);
        end
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/adc_cap_buf.sv
// Simple dual-port sample buffer, DEPTH x ADC_W, with a registered read port.
module adc_cap_buf #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned ADC_W = 14
) (
    input  logic                     sys_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ADC_W-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ADC_W-1:0]         rd_data
);

    logic [ADC_W-1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// N-channel ADC snapshot capture engine on the FSMC register bus.
// Optional hardware level trigger enabled by defining HW_TRIG_EN.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int unsigned CH_NUM    = 2,
    parameter int unsigned ADC_W     = 14,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [CH_NUM*ADC_W-1:0] ad_data,
    input  logic [CH_NUM-1:0]       ad_of,
    input  logic [31:0]             bus_addr,
    input  logic                    bus_wr_en,
    input  logic [31:0]             bus_wdata,
    input  logic                    bus_rd_en,
    output logic [31:0]             bus_rdata,
    output logic                    bus_rvalid,
    output logic                    irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cap_state_e state_q, state_d;

    logic [CH_NUM-1:0] ch_en_q, ch_en_act_q;
    logic [15:0]       decim_q, decim_act_q, dcnt_q, len_q;
    logic [CW-1:0]     len_act_q, count_q, count_inc;
    logic              done_q, ovr_q;
    logic [CW-1:0]     rd_ptr_q [CH_NUM];

    logic        rd_stage_q, rd_pop_q, bus_rvalid_q;
    logic [2:0]  rd_ch_q;
    logic [31:0] rd_reg_q, reg_rdata, bus_rdata_q;

    logic              blk_hit, wr_hit, rd_hit, ctrl_wr, data_win;
    logic [7:0]        off;
    logic              cmd_arm, cmd_trig, cmd_abort, arm_ok, hw_trig;
    logic              store_en, cap_last;
    logic [CH_NUM-1:0] pop;
    logic [ADC_W-1:0]  ram_rdata [CH_NUM];
    logic [ADC_W-1:0]  ram_sel;
    logic              unused_wdata;

    assign blk_hit      = (bus_addr[31:8] == BASE_ADDR[31:8]);
    assign off          = bus_addr[7:0];
    assign wr_hit       = bus_wr_en & blk_hit;
    assign rd_hit       = bus_rd_en & blk_hit;
    assign ctrl_wr      = wr_hit & (off == RegCtrl);
    assign cmd_arm      = ctrl_wr & bus_wdata[CtrlArm];
    assign cmd_trig     = ctrl_wr & bus_wdata[CtrlSwTrig];
    assign cmd_abort    = ctrl_wr & bus_wdata[CtrlAbort];
    assign arm_ok       = cmd_arm & ~cmd_abort & ((state_q == StIdle) | (state_q == StDone));
    assign count_inc    = count_q + CW'(1);
    assign data_win     = rd_hit & (off[7:3] == DataBase[7:3]);
    assign unused_wdata = ^bus_wdata[31:16];

`ifdef HW_TRIG_EN
    logic [ADC_W-1:0] trig_lvl_q, prev_q, src_cur;
    logic [2:0]       trig_src_q;
    logic             trig_fall_q, src_ok;

    always_comb begin
        src_cur = '0;
        src_ok  = 1'b0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (trig_src_q == 3'(c)) begin
                src_cur = ad_data[c*ADC_W +: ADC_W];
                src_ok  = 1'b1;
            end
        end
    end

    assign hw_trig = (state_q == StArmed) && src_ok &&
                     (trig_fall_q ? (prev_q >= trig_lvl_q && trig_lvl_q > src_cur)
                                  : (prev_q < trig_lvl_q && trig_lvl_q <= src_cur));

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            trig_lvl_q  <= '0;
            trig_src_q  <= '0;
            trig_fall_q <= 1'b0;
            prev_q      <= '0;
        end else begin
            if (wr_hit && off == RegTrigLvl) begin
                trig_lvl_q <= bus_wdata[ADC_W-1:0];
            end
            if (wr_hit && off == RegTrigCfg) begin
                trig_src_q  <= bus_wdata[2:0];
                trig_fall_q <= bus_wdata[TrigCfgFall];
            end
            prev_q <= arm_ok ? '0 : src_cur;
        end
    end
`else
    assign hw_trig = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cmd_abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: if (cmd_arm) state_d = cmd_trig ? StCapture : StArmed;
                StArmed:        if (cmd_trig || hw_trig) state_d = StCapture;
                StCapture:      if (cap_last) state_d = StDone;
                default:        state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        store_en = (state_q == StCapture) && (dcnt_q == '0);
        cap_last = store_en && (count_inc == len_act_q);
        irq      = done_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ch_en_q     <= '0;
            decim_q     <= '0;
            len_q       <= '0;
            ch_en_act_q <= '0;
            decim_act_q <= '0;
            len_act_q   <= '0;
            dcnt_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            for (int c = 0; c < CH_NUM; c++) begin
                rd_ptr_q[c] <= '0;
            end
        end else begin
            if (wr_hit) begin
                case (off)
                    RegCtrl:  ch_en_q <= bus_wdata[CtrlChEn +: CH_NUM];
                    RegDecim: decim_q <= bus_wdata[15:0];
                    RegLen:   len_q   <= bus_wdata[15:0];
                    default: ;
                endcase
            end
            if (cmd_abort) begin
                count_q <= '0;
                done_q  <= 1'b0;
            end else if (arm_ok) begin
                // Arming write carries the channel mask for this capture.
                ch_en_act_q <= bus_wdata[CtrlChEn +: CH_NUM];
                decim_act_q <= decim_q;
                len_act_q   <= CW'(eff_len(len_q, DEPTH));
                dcnt_q      <= '0;
                count_q     <= '0;
                done_q      <= 1'b0;
                ovr_q       <= 1'b0;
            end else if (state_q == StCapture) begin
                dcnt_q <= (dcnt_q == decim_act_q) ? '0 : dcnt_q + 16'd1;
                if (store_en) count_q <= count_inc;
                if (cap_last) done_q <= 1'b1;
                if (|(ad_of & ch_en_act_q)) ovr_q <= 1'b1;
            end
            for (int c = 0; c < CH_NUM; c++) begin
                if (arm_ok) begin
                    rd_ptr_q[c] <= '0;
                end else if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            pop[c] = data_win && (off[2:0] == 3'(c)) && ch_en_act_q[c] && (rd_ptr_q[c] < count_q);
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_buf
        adc_cap_buf #(
            .DEPTH (DEPTH),
            .ADC_W (ADC_W)
        ) u_buf (
            .sys_clk (sys_clk),
            .wr_en   (store_en & ch_en_act_q[c]),
            .wr_addr (count_q[AW-1:0]),
            .wr_data (ad_data[c*ADC_W +: ADC_W]),
            .rd_en   (pop[c]),
            .rd_addr (rd_ptr_q[c][AW-1:0]),
            .rd_data (ram_rdata[c])
        );
    end

    // Register values are snapshotted at the strobe so a coincident write is not seen.
    always_comb begin
        reg_rdata = '0;
        case (off)
            RegCtrl:    reg_rdata[CtrlChEn +: CH_NUM] = ch_en_q;
            RegDecim:   reg_rdata[15:0] = decim_q;
            RegLen:     reg_rdata[15:0] = len_q;
            RegStatus:  reg_rdata = {16'(count_q), 12'd0, ovr_q, done_q, state_q};
`ifdef HW_TRIG_EN
            RegTrigLvl: reg_rdata[ADC_W-1:0] = trig_lvl_q;
            RegTrigCfg: reg_rdata = {23'd0, trig_fall_q, 5'd0, trig_src_q};
`endif
            default: ;
        endcase
        if (!blk_hit) begin
            reg_rdata = '0;
        end
    end

    always_comb begin
        ram_sel = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (rd_ch_q == 3'(c)) begin
                ram_sel = ram_rdata[c];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rd_stage_q   <= 1'b0;
            rd_pop_q     <= 1'b0;
            rd_ch_q      <= '0;
            rd_reg_q     <= '0;
            bus_rvalid_q <= 1'b0;
            bus_rdata_q  <= '0;
        end else begin
            rd_stage_q   <= bus_rd_en;
            rd_pop_q     <= |pop;
            rd_ch_q      <= off[2:0];
            rd_reg_q     <= reg_rdata;
            bus_rvalid_q <= rd_stage_q;
            if (rd_stage_q) begin
                bus_rdata_q <= rd_pop_q ? 32'(ram_sel) : rd_reg_q;
            end else begin
                bus_rdata_q <= '0;
            end
        end
    end

    assign bus_rdata  = bus_rdata_q;
    assign bus_rvalid = bus_rvalid_q;

endmodule
